// File: rtl/div_restoring_fixed_unsigned.sv
// Sequential restoring divider for unsigned operands: one quotient bit per clock,
// MSB first, with a single-cycle completion pulse and a divide-by-zero flag.
module div_restoring_fixed_unsigned #(
  parameter int div_len = 24,
  parameter int dvd_len = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [dvd_len-1:0] dividend,
  input  logic [div_len-1:0] divisor,
  output logic [dvd_len-1:0] quotient,
  output logic [div_len-1:0] remainder,
  output logic               div_done,
  output logic               busy,
  output logic               div_by_zero
);

  localparam int cnt_w = (dvd_len > 1) ? $clog2(dvd_len) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [cnt_w-1:0]   cnt;
  logic [div_len-1:0] pr;
  logic [div_len-1:0] dsr;
  logic [dvd_len-1:0] dvd;

  logic [div_len:0]   pr_shift;
  logic               ge;
  logic [div_len-1:0] pr_next;
  logic [dvd_len-1:0] dvd_next;

  // Dividend bits leave at the top of dvd while quotient bits enter at the
  // bottom, so after dvd_len steps dvd holds the quotient. The stored
  // remainder is always < divisor, so only the shifted value needs the extra bit.
  always_comb begin
    pr_shift = {pr, dvd[dvd_len-1]};
    ge       = (pr_shift >= {1'b0, dsr});
    pr_next  = ge ? (pr_shift[div_len-1:0] - dsr) : pr_shift[div_len-1:0];
    dvd_next = {dvd[dvd_len-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dsr         <= '0;
      dvd         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_done    <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (start) begin
            dvd   <= dividend;
            dsr   <= divisor;
            pr    <= '0;
            cnt   <= cnt_w'(dvd_len - 1);
            busy  <= 1'b1;
            state <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          pr  <= pr_next;
          dvd <= dvd_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient    <= dvd_next;
            remainder   <= pr_next;
            div_done    <= 1'b1;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          // busy still set here only on the divide-by-zero path, which
          // reports its result from this state instead of from RUN.
          if (busy) begin
            quotient    <= '1;
            remainder   <= dvd[div_len-1:0];
            div_by_zero <= 1'b1;
            div_done    <= 1'b1;
            busy        <= 1'b0;
          end else begin
            div_done <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_fixed_unsigned.sv
// Scoreboard bench for div_restoring_fixed_unsigned: directed corner cases plus
// random operands checked against / and % from a behavioural model.
module tb_div_restoring_fixed_unsigned;

  localparam int DIV = 24;
  localparam int DVD = 48;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DVD-1:0] dividend = '0;
  logic [DIV-1:0] divisor = '0;
  logic [DVD-1:0] quotient;
  logic [DIV-1:0] remainder;
  logic           div_done;
  logic           busy;
  logic           div_by_zero;

  div_restoring_fixed_unsigned #(.div_len(DIV), .dvd_len(DVD)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_done(div_done),
    .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DVD-1:0] q;
    logic [DIV-1:0] r;
    logic           dz;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [DVD-1:0] a, input logic [DIV-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a[DIV-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / DVD'(b);
      e.r  = DIV'(a % DVD'(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && div_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got div_done=1 expected no completion at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge (edge N).
  task automatic run_op(input logic [DVD-1:0] a, input logic [DIV-1:0] b, input bit hold);
    exp_t e;
    int   lat;
    int   k;
    e   = model(a, b);
    lat = (b == 0) ? 1 : DVD;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(e);
    for (k = 0; k <= 2000; k++) begin
      @(negedge clk);
      if (hold) begin
        dividend = {$urandom, $urandom};
        divisor  = DIV'($urandom);
      end else begin
        start = 1'b0;
      end
      if (div_done) break;
      chk("busy_in_flight", 64'(busy), 64'd1);
      chk("quotient_hold", 64'(quotient), 64'(last.q));
      chk("remainder_hold", 64'(remainder), 64'(last.r));
      chk("dz_hold", 64'(div_by_zero), 64'(last.dz));
    end
    if (k > 2000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no div_done expected within 2000 cycles");
    end else begin
      chk("latency", 64'(k), 64'(lat));
      chk("busy_at_done", 64'(busy), 64'd0);
    end
    @(negedge clk);
    chk("done_pulse_width", 64'(div_done), 64'd0);
    chk("no_reaccept_in_done", 64'(busy), 64'd0);
    start = 1'b0;
    last  = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit             seen;
    logic [DVD-1:0] a;
    logic [DIV-1:0] b;
    last = '{q: '0, r: '0, dz: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_done", 64'(div_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);

    // Start presented on the very first edge with rst low.
    rst = 1'b0;
    run_op(48'd100, 24'd7, 1'b0);
    run_op(48'hFFFF_FFFF_FFFF, 24'hFF_FFFF, 1'b0);
    run_op(48'd3, 24'd10, 1'b0);
    run_op(48'd5, 24'd0, 1'b0);
    run_op(48'd1000, 24'd13, 1'b1);
    run_op(48'hABCD_1234_5678, 24'h00_0003, 1'b1);

    // Reset in the middle of RUN: no completion may follow.
    dividend = 48'd100;
    divisor  = 24'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_done", 64'(div_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_dz", 64'(div_by_zero), 64'd0);
    last = '{q: '0, r: '0, dz: 1'b0};
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (div_done) seen = 1'b1;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    run_op(48'd100, 24'd7, 1'b0);

    for (int i = 0; i < 200; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      a   = {$urandom, $urandom};
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 24'd1;
      else if (sel == 2) b = DIV'($urandom_range(2, 255));
      else               b = DIV'($urandom);
      if ($urandom_range(0, 7) == 0) a = DVD'($urandom_range(0, 1000));
      run_op(a, b, 1'b0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_restoring_fixed_unsigned.md
DIV_RESTORING_FIXED_UNSIGNED -- requirements
Module: div_restoring_fixed_unsigned

Interface
REQ-001 The module SHALL have parameter div_len, default 24: divisor and remainder width.
REQ-002 The module SHALL have parameter dvd_len, default 48: dividend and quotient width, with dvd_len >= div_len.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: request a division, sampled on the rising edge.
REQ-006 The module SHALL have port dividend, input, dvd_len bits: unsigned dividend, sampled when start is accepted.
REQ-007 The module SHALL have port divisor, input, div_len bits: unsigned divisor, sampled when start is accepted.
REQ-008 The module SHALL have port quotient, output, dvd_len bits: registered quotient.
REQ-009 The module SHALL have port remainder, output, div_len bits: registered remainder.
REQ-010 The module SHALL have port div_done, output, 1 bit: registered one-cycle completion pulse.
REQ-011 The module SHALL have port busy, output, 1 bit: registered, high while an accepted operation is in progress.
REQ-012 The module SHALL have port div_by_zero, output, 1 bit: registered flag, valid with div_done.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at rising edge N SHALL latch the operands, set busy=1, and load the iteration counter with dvd_len-1.
- Nonzero divisor: the next state SHALL be RUN.
- divisor=0: the next state SHALL be DONE.
REQ-015 start SHALL be ignored in RUN and in DONE, with no effect on operands, counter or outputs.
REQ-016 RUN SHALL perform one restoring step per cycle, MSB of dividend first:
- pr = {pr[div_len-1:0], next dividend bit}, where pr is the div_len+1-bit partial remainder;
- if pr >= divisor: pr = pr - divisor and the quotient bit is 1;
- otherwise the quotient bit is 0.
REQ-017 RUN SHALL last exactly dvd_len cycles, covering edges N+1 through N+dvd_len; the counter SHALL decrement once per step and RUN SHALL exit when the counter is 0.
REQ-018 At edge N+dvd_len the module SHALL do all of the following together:
- register quotient and remainder;
- set div_done=1, busy=0, div_by_zero=0;
- move to DONE.
REQ-019 DONE SHALL last one cycle; at the next edge div_done SHALL go to 0 and the state SHALL return to IDLE.
REQ-020 For divisor=0, the following SHALL happen at edge N+1:
- quotient = all ones;
- remainder = dividend[div_len-1:0];
- div_by_zero=1, div_done=1, busy=0.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next accepted operation completes, and SHALL NOT change during RUN.
REQ-022 The results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every divisor != 0.
REQ-023 The remainder SHALL always fit in div_len bits, and pr bit div_len SHALL be used only for the compare.
REQ-024 A new operation SHALL be accepted no earlier than the IDLE cycle that follows DONE, giving a minimum start-to-start spacing of dvd_len+2 cycles.

Reset
REQ-025 rst=1 at a rising edge SHALL force the following, overriding start and any in-flight operation:
- state = IDLE;
- counter = 0 and pr = 0;
- quotient = 0 and remainder = 0;
- div_done = 0, busy = 0, div_by_zero = 0.
REQ-026 An operation interrupted by reset SHALL never produce div_done.
REQ-027 start SHALL be accepted on the first rising edge at which rst=0.

Verification
REQ-028 The bench SHALL cover: dividend=100, divisor=7, start at edge N -> quotient=14, remainder=2, div_done high only in the cycle after edge N+48, busy high between edges N and N+48.
REQ-029 The bench SHALL cover: dividend=48'hFFFF_FFFF_FFFF, divisor=24'hFFFFFF -> quotient=48'h000001000001, remainder=0, div_by_zero=0.
REQ-030 The bench SHALL cover: dividend=3, divisor=10 -> quotient=0, remainder=3; then dividend=5, divisor=0 -> div_done at edge N+1, quotient=48'hFFFF_FFFF_FFFF, remainder=5, div_by_zero=1.
REQ-031 The bench SHALL cover: start held high continuously, with operands changing during RUN -> result uses only the operands sampled at acceptance; next acceptance occurs only after DONE.
REQ-032 The bench SHALL cover: rst asserted for one cycle 20 cycles into RUN -> next cycle all outputs 0 and no div_done; a following 100/7 run then completes correctly.
REQ-033 The bench SHALL cover: 200 random operand pairs including divisor=0 and divisor=1 -> each result matches the SystemVerilog / and % reference, with a 2000-cycle timeout on div_done per operation.
